// File: rtl/fc_layer.sv
// fc_layer: fully-connected output stage. Streams the flattened L2 vector
// against a weight ROM, adds a per-neuron bias, rounds/saturates to Q4.16
// and writes one result per neuron into result bank 3'b110.
// Optional build macro FC_RELU_EN: clamp negative results to zero.
module fc_layer #(
   parameter int unsigned IN_LEN  = 2048,
   parameter int unsigned OUT_LEN = 10,
   parameter int unsigned ACC_W   = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        crd,
   output logic [11:0] caddr_rd,
   input  logic [19:0] cdata_rd,
   output logic [2:0]  csel,
   output logic [14:0] waddr,
   input  logic [19:0] wdata,
   output logic [3:0]  baddr,
   input  logic [19:0] bdata,
   output logic        cwr,
   output logic [11:0] caddr_wr,
   output logic [19:0] cdata_wr
);

   localparam int unsigned DATA_W  = 20;
   localparam int unsigned PROD_W  = 2 * DATA_W;
   localparam int unsigned CADDR_W = 12;
   localparam int unsigned WADDR_W = 15;
   localparam int unsigned NRN_W   = 4;
   localparam int unsigned CNT_W   = $clog2(IN_LEN + 2);
   localparam int unsigned FRAC_W  = 16;

   localparam logic [2:0] CSEL_RD = 3'b101;
   localparam logic [2:0] CSEL_WR = 3'b110;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(32768);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(524287);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-524288);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_MAC,
      S_DRAIN,
      S_ROUND,
      S_WRITE,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NRN_W-1:0]  neuron_q, neuron_d;
   logic [NRN_W-1:0]  nrn_inc;
   logic [CNT_W-1:0]  issue_idx;
   logic              issue_ok;

   logic signed [ACC_W-1:0]  acc_q;
   logic signed [PROD_W-1:0] prod_q;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  bias_ext_c;
   logic signed [ACC_W-1:0]  rnd_c;
   logic [DATA_W-1:0]        sat_c;
   logic [DATA_W-1:0]        result_c;

   logic               busy_d, done_d, crd_d, cwr_d;
   logic [2:0]         csel_d;
   logic [CADDR_W-1:0] caddr_rd_d, caddr_wr_d;
   logic [WADDR_W-1:0] waddr_d;
   logic [NRN_W-1:0]   baddr_d;
   logic [DATA_W-1:0]  cdata_wr_d;

   // Weight ROM address for (neuron, index) pair.
   function automatic logic [WADDR_W-1:0] waddr_of(input logic [NRN_W-1:0] n,
                                                   input logic [CNT_W-1:0] i);
      return WADDR_W'(WADDR_W'(n) * WADDR_W'(IN_LEN) + WADDR_W'(i));
   endfunction

   // Index of the next read address and whether it is still inside the vector.
   always_comb begin
      issue_idx = (state_q == S_BIAS) ? CNT_W'(1) : cnt_q + CNT_W'(2);
      issue_ok  = issue_idx < CNT_W'(IN_LEN);
      nrn_inc   = neuron_q + NRN_W'(1);
   end

   // Signed product of the returned activation/weight pair and the bias aligned to Q8.32.
   always_comb begin
      prod_c     = PROD_W'(signed'(cdata_rd)) * PROD_W'(signed'(wdata));
      bias_ext_c = ACC_W'(signed'(bdata)) <<< FRAC_W;
   end

   // Round half-up back to Q4.16, saturate, optionally clamp negatives.
   always_comb begin
      rnd_c = (acc_q + RND_HALF) >>> FRAC_W;
      if (rnd_c > SAT_MAX) begin
         sat_c = 20'h7FFFF;
      end else if (rnd_c < SAT_MIN) begin
         sat_c = 20'h80000;
      end else begin
         sat_c = rnd_c[DATA_W-1:0];
      end
`ifdef FC_RELU_EN
      result_c = sat_c[DATA_W-1] ? '0 : sat_c;
`else
      result_c = sat_c;
`endif
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         neuron_q <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         csel     <= '0;
         caddr_rd <= '0;
         waddr    <= '0;
         baddr    <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         neuron_q <= neuron_d;
         busy     <= busy_d;
         done     <= done_d;
         crd      <= crd_d;
         cwr      <= cwr_d;
         csel     <= csel_d;
         caddr_rd <= caddr_rd_d;
         waddr    <= waddr_d;
         baddr    <= baddr_d;
         caddr_wr <= caddr_wr_d;
         cdata_wr <= cdata_wr_d;
      end
   end

   // Next-state and next-output logic; outputs become visible in the state they belong to.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      neuron_d   = neuron_q;
      busy_d     = busy;
      done_d     = 1'b0;
      crd_d      = 1'b0;
      cwr_d      = 1'b0;
      csel_d     = csel;
      caddr_rd_d = caddr_rd;
      waddr_d    = waddr;
      baddr_d    = baddr;
      caddr_wr_d = caddr_wr;
      cdata_wr_d = cdata_wr;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_BIAS;
               busy_d     = 1'b1;
               cnt_d      = '0;
               crd_d      = 1'b1;
               csel_d     = CSEL_RD;
               caddr_rd_d = '0;
               waddr_d    = waddr_of(neuron_q, '0);
               baddr_d    = neuron_q;
            end
         end
         S_BIAS: begin
            state_d = S_MAC;
            cnt_d   = '0;
            if (issue_ok) begin
               crd_d      = 1'b1;
               caddr_rd_d = CADDR_W'(issue_idx);
               waddr_d    = waddr_of(neuron_q, issue_idx);
            end
         end
         S_MAC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (issue_ok) begin
               crd_d      = 1'b1;
               caddr_rd_d = CADDR_W'(issue_idx);
               waddr_d    = waddr_of(neuron_q, issue_idx);
            end
            if (cnt_q == CNT_W'(IN_LEN - 1)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            state_d = S_ROUND;
         end
         S_ROUND: begin
            state_d    = S_WRITE;
            cwr_d      = 1'b1;
            csel_d     = CSEL_WR;
            caddr_wr_d = CADDR_W'(neuron_q);
            cdata_wr_d = result_c;
         end
         S_WRITE: begin
            cnt_d = '0;
            if (neuron_q == NRN_W'(OUT_LEN - 1)) begin
               state_d  = S_FIN;
               neuron_d = '0;
            end else begin
               state_d    = S_BIAS;
               neuron_d   = nrn_inc;
               crd_d      = 1'b1;
               csel_d     = CSEL_RD;
               caddr_rd_d = '0;
               waddr_d    = waddr_of(nrn_inc, '0);
               baddr_d    = nrn_inc;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // MAC pipeline: product registered once, accumulated the following cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         prod_q <= '0;
      end else begin
         unique case (state_q)
            S_MAC: begin
               if (cnt_q == '0) begin
                  acc_q <= bias_ext_c;
               end else begin
                  acc_q <= acc_q + ACC_W'(prod_q);
               end
               prod_q <= prod_c;
            end
            S_DRAIN: begin
               acc_q <= acc_q + ACC_W'(prod_q);
            end
            default: begin
               acc_q  <= acc_q;
               prod_q <= prod_q;
            end
         endcase
      end
   end

endmodule
